ship_placer: RTL and testbench

//  Places the fleet on the board at game start. Sequences the LFSR random source:

---
 rtl/ship_placer.sv | 213 +++++++++++++++++++++
 tb/tb_ship_placer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_placer.sv
// ship_placer
//   Places the fleet on the board at game start. For each ship it asks the
//   random source for a start cell and direction, checks bounds and then
//   overlap cell by cell against an internal occupancy bitmap, and on
//   success writes the ship's cells to board RAM one per cycle.
//
// Ports
//   clock, reset        system clock (rising edge), async active-high reset
//   start               begin a placement run (honoured in IDLE/DONE/FAIL)
//   rnd_req             one-cycle request for a new random sample
//   rnd_valid           sample present on rnd_x/rnd_y/rnd_dir
//   rnd_x, rnd_y        candidate start column / row
//   rnd_dir             0 = horizontal, 1 = vertical
//   wr_en/addr/data     registered board RAM write port (ship index + 1)
//   ship_idx            ship currently being placed
//   busy, done, fail    run status
//   tries_total         (PLACER_STATS_EN only) rejections since last start
//
// Build option: define PLACER_STATS_EN to add the tries_total counter port.

module ship_placer #(
  parameter int          BOARD_SIZE = 10,
  parameter int          NUM_SHIPS  = 4,
  parameter logic [15:0] SHIP_LENS  = 16'h2334,
  parameter int          MAX_TRIES  = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       rnd_req,
  input  logic       rnd_valid,
  input  logic [3:0] rnd_x,
  input  logic [3:0] rnd_y,
  input  logic       rnd_dir,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [2:0] wr_data,
  output logic [2:0] ship_idx,
  output logic       busy,
  output logic       done,
  output logic       fail
`ifdef PLACER_STATS_EN
  ,
  output logic [15:0] tries_total
`endif
);

  localparam int CELLS = BOARD_SIZE * BOARD_SIZE;
  localparam int AW    = $clog2(CELLS);
  localparam int MAP   = 1 << AW;
  localparam int TW    = $clog2(MAX_TRIES + 1);

  localparam logic [4:0]    BS5       = 5'(BOARD_SIZE);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
  localparam logic [2:0]    LAST_SHIP = 3'(NUM_SHIPS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, REQ, WAIT, CHECK, WRITE, DONE, FAIL
  } state_t;

  state_t         state, state_n;
  logic [2:0]     ship_idx_n;
  logic [TW-1:0]  tries, tries_n;
  logic [3:0]     cand_x, cand_x_n, cand_y, cand_y_n;
  logic           cand_dir, cand_dir_n;
  logic [3:0]     offset, offset_n;
  logic [MAP-1:0] bitmap, bitmap_n;
  logic           wr_en_n;
  logic [6:0]     wr_addr_n;
  logic [2:0]     wr_data_n;

  logic [3:0] len;
  logic [4:0] cell_x, cell_y, end_pos;
  logic [7:0] cell_addr;
  logic       range_bad, cell_occ, last_cell, reject;

  // Geometry of the cell under test: the start cell plus the walking offset
  // along the chosen direction, and the far end of the ship for the range test.
  // Everything is kept at 5 bits so that start+len-1 cannot wrap.
  assign len       = SHIP_LENS[ship_idx*4 +: 4];
  assign cell_x    = {1'b0, cand_x} + (cand_dir ? 5'd0 : {1'b0, offset});
  assign cell_y    = {1'b0, cand_y} + (cand_dir ? {1'b0, offset} : 5'd0);
  assign end_pos   = (cand_dir ? {1'b0, cand_y} : {1'b0, cand_x}) + {1'b0, len} - 5'd1;
  assign cell_addr = {3'b000, cell_y} * {3'b000, BS5} + {3'b000, cell_x};
  assign range_bad = ({1'b0, cand_x} >= BS5) || ({1'b0, cand_y} >= BS5) || (end_pos >= BS5);
  assign cell_occ  = bitmap[cell_addr[AW-1:0]];
  assign last_cell = (offset == len - 4'd1);
  // The range test is re-evaluated on every CHECK cycle; the candidate is
  // constant there, so in practice only the first cycle can trip it, and it
  // shields the bitmap lookup from aliased out-of-board addresses.
  assign reject    = (state == CHECK) && (range_bad || cell_occ);

  // State and datapath registers; everything returns to the idle image on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ship_idx <= '0;
      tries    <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
      cand_dir <= 1'b0;
      offset   <= '0;
      bitmap   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      ship_idx <= ship_idx_n;
      tries    <= tries_n;
      cand_x   <= cand_x_n;
      cand_y   <= cand_y_n;
      cand_dir <= cand_dir_n;
      offset   <= offset_n;
      bitmap   <= bitmap_n;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
    end
  end

  // Next-state and datapath decisions. The write port defaults to idle with a
  // zero address/data so RAM sees clean values whenever wr_en is low.
  always_comb begin
    state_n    = state;
    ship_idx_n = ship_idx;
    tries_n    = tries;
    cand_x_n   = cand_x;
    cand_y_n   = cand_y;
    cand_dir_n = cand_dir;
    offset_n   = offset;
    bitmap_n   = bitmap;
    wr_en_n    = 1'b0;
    wr_addr_n  = '0;
    wr_data_n  = '0;
    rnd_req    = (state == REQ);
    busy       = (state == CLEAR) || (state == REQ) || (state == WAIT) ||
                 (state == CHECK) || (state == WRITE);
    done       = (state == DONE);
    fail       = (state == FAIL);

    case (state)
      IDLE, DONE, FAIL: begin
        if (start) state_n = CLEAR;
      end
      CLEAR: begin
        bitmap_n   = '0;
        ship_idx_n = '0;
        tries_n    = '0;
        offset_n   = '0;
        state_n    = REQ;
      end
      REQ: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (rnd_valid) begin
          cand_x_n   = rnd_x;
          cand_y_n   = rnd_y;
          cand_dir_n = rnd_dir;
          offset_n   = '0;
          state_n    = CHECK;
        end
      end
      CHECK: begin
        if (reject) begin
          tries_n  = tries + 1'b1;
          offset_n = '0;
          state_n  = (tries + 1'b1 == TRIES_MAX) ? FAIL : REQ;
        end else if (last_cell) begin
          offset_n = '0;
          state_n  = WRITE;
        end else begin
          offset_n = offset + 4'd1;
        end
      end
      WRITE: begin
        wr_en_n   = 1'b1;
        wr_addr_n = cell_addr[6:0];
        wr_data_n = ship_idx + 3'd1;
        bitmap_n[cell_addr[AW-1:0]] = 1'b1;
        if (last_cell) begin
          offset_n = '0;
          tries_n  = '0;
          if (ship_idx == LAST_SHIP) begin
            state_n = DONE;
          end else begin
            ship_idx_n = ship_idx + 3'd1;
            state_n    = REQ;
          end
        end else begin
          offset_n = offset + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PLACER_STATS_EN
  // Running count of rejected candidates for the whole run, held at all-ones
  // rather than wrapping so a long unlucky run still reads as "very many".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tries_total <= '0;
    end else if (state == CLEAR) begin
      tries_total <= '0;
    end else if (reject && (tries_total != 16'hFFFF)) begin
      tries_total <= tries_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ship_placer.sv
// tb_ship_placer
//   Directed bench for ship_placer. A responder answers every rnd_req two
//   cycles later from a scripted candidate list (falling back to an always
//   out-of-range candidate when the list is exhausted); monitors log every
//   board write and count request pulses for comparison against hand-built
//   expected write lists.

module tb_ship_placer;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       dir;
  } cand_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rnd_req;
  logic        rnd_valid;
  logic [3:0]  rnd_x;
  logic [3:0]  rnd_y;
  logic        rnd_dir;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [2:0]  wr_data;
  logic [2:0]  ship_idx;
  logic        busy;
  logic        done;
  logic        fail;
`ifdef PLACER_STATS_EN
  logic [15:0] tries_total;
`endif

  int vectors     = 0;
  int miscompares = 0;

  cand_t       script[$];
  int          read_idx  = 0;
  int          skip_to   = 0;
  logic [9:0]  wr_log[$];
  logic [9:0]  exp_log[$];
  int          req_count = 0;

  ship_placer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rnd_req   (rnd_req),
    .rnd_valid (rnd_valid),
    .rnd_x     (rnd_x),
    .rnd_y     (rnd_y),
    .rnd_dir   (rnd_dir),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ship_idx  (ship_idx),
    .busy      (busy),
    .done      (done),
    .fail      (fail)
`ifdef PLACER_STATS_EN
    ,
    .tries_total (tries_total)
`endif
  );

  always #5 clock = ~clock;

  // Monitors: log each registered write and count request pulses.
  always @(posedge clock) begin
    if (!reset) begin
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
      if (rnd_req) req_count++;
    end
  end

  // Random-source model: sample appears two cycles after each request.
  initial begin
    cand_t c;
    rnd_valid = 1'b0;
    rnd_x     = '0;
    rnd_y     = '0;
    rnd_dir   = 1'b0;
    forever begin
      @(posedge clock);
      if (rnd_req === 1'b1 && !reset) begin
        @(posedge clock);
        #1;
        if (read_idx < skip_to) read_idx = skip_to;
        if (read_idx < script.size()) begin
          c = script[read_idx];
          read_idx++;
        end else begin
          c = '{x: 4'd15, y: 4'd15, dir: 1'b0};
        end
        rnd_x     = c.x;
        rnd_y     = c.y;
        rnd_dir   = c.dir;
        rnd_valid = 1'b1;
        @(posedge clock);
        #1 rnd_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic push_cand(input int x, input int y, input int dir);
    script.push_back('{x: 4'(x), y: 4'(y), dir: 1'(dir)});
  endtask

  task automatic expect_ship(input int first, input int step, input int len,
                             input int data);
    for (int i = 0; i < len; i++)
      exp_log.push_back({7'(first + i * step), 3'(data)});
  endtask

  task automatic wait_end(input int budget, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if (done || fail) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_writes(input string tag, input int base);
    int n;
    n = wr_log.size() - base;
    checkOutput({tag, "_wr_count"}, n, exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      checkOutput($sformatf("%s_wr%0d", tag, i),
                  (i < n) ? {22'd0, wr_log[base + i]} : 32'hFFFF_FFFF,
                  {22'd0, exp_log[i]});
    end
  endtask

  task automatic push_script2();
    push_cand(0, 0, 0);
    push_cand(0, 1, 0);
    push_cand(0, 2, 0);
    push_cand(0, 3, 0);
  endtask

  task automatic expect_script2();
    exp_log.delete();
    expect_ship(0, 1, 4, 1);
    expect_ship(10, 1, 3, 2);
    expect_ship(20, 1, 3, 3);
    expect_ship(30, 1, 2, 4);
  endtask

  initial begin
    logic to;
    int   wr_base;
    int   req_base;

    // 1: reset asserted while idle
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_rnd_req", rnd_req, 0);
    checkOutput("rst_ship_idx", ship_idx, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // 2: every candidate accepted first time
    push_script2();
    expect_script2();
    wr_base = wr_log.size(); req_base = req_count;
    applyStimulus();
    checkOutput("s2_busy_run", busy, 1);
    wait_end(2000, to);
    checkOutput("s2_timeout", to, 0);
    @(posedge clock); #1;
    checkOutput("s2_done", done, 1);
    checkOutput("s2_fail", fail, 0);
    checkOutput("s2_busy", busy, 0);
    checkOutput("s2_req", req_count - req_base, 4);
    check_writes("s2", wr_base);

    // 3: range rejections before a flush-right ship 0
    push_cand(12, 3, 1);
    push_cand(7, 0, 0);
    push_cand(6, 0, 0);
    push_cand(0, 1, 0);
    push_cand(0, 2, 0);
    push_cand(0, 3, 0);
    exp_log.delete();
    expect_ship(6, 1, 4, 1);
    expect_ship(10, 1, 3, 2);
    expect_ship(20, 1, 3, 3);
    expect_ship(30, 1, 2, 4);
    wr_base = wr_log.size(); req_base = req_count;
    applyStimulus();
    checkOutput("s3_done_drop", done, 0);
    wait_end(2000, to);
    checkOutput("s3_timeout", to, 0);
    @(posedge clock); #1;
    checkOutput("s3_done", done, 1);
    checkOutput("s3_req", req_count - req_base, 6);
    check_writes("s3", wr_base);

    // 4: vertical ship, overlap rejection in the middle of a candidate
    push_cand(0, 0, 1);
    push_cand(0, 2, 0);
    push_cand(1, 0, 0);
    push_cand(0, 4, 0);
    push_cand(5, 5, 1);
    exp_log.delete();
    expect_ship(0, 10, 4, 1);
    expect_ship(1, 1, 3, 2);
    expect_ship(40, 1, 3, 3);
    expect_ship(55, 10, 2, 4);
    wr_base = wr_log.size(); req_base = req_count;
    applyStimulus();
    wait_end(2000, to);
    checkOutput("s4_timeout", to, 0);
    @(posedge clock); #1;
    checkOutput("s4_done", done, 1);
    checkOutput("s4_req", req_count - req_base, 5);
    check_writes("s4", wr_base);

    // 5: script exhausted -> every candidate off-board -> fail after 64 tries
    wr_base = wr_log.size(); req_base = req_count;
    applyStimulus();
    wait_end(2000, to);
    checkOutput("s5_timeout", to, 0);
    @(posedge clock); #1;
    checkOutput("s5_fail", fail, 1);
    checkOutput("s5_done", done, 0);
    checkOutput("s5_busy", busy, 0);
    checkOutput("s5_req", req_count - req_base, 64);
    checkOutput("s5_wr", wr_log.size() - wr_base, 0);
`ifdef PLACER_STATS_EN
    checkOutput("s5_tries_total", tries_total, 64);
`endif
    applyStimulus();
    checkOutput("s5_fail_clear", fail, 0);
    checkOutput("s5_busy_again", busy, 1);

    // 6: reset in the middle of ship 1's write burst, then a clean rerun
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    skip_to = script.size();
    push_script2();
    applyStimulus();
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      if (wr_en && wr_data == 3'd2) begin
        to = 1'b0;
        break;
      end
    end
    checkOutput("s6_reach_ship1", to, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("s6_wr_en_rst", wr_en, 0);
    checkOutput("s6_busy_rst", busy, 0);
    checkOutput("s6_idx_rst", ship_idx, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    skip_to = script.size();
    push_script2();
    expect_script2();
    wr_base = wr_log.size(); req_base = req_count;
    applyStimulus();
    wait_end(2000, to);
    checkOutput("s6_timeout", to, 0);
    @(posedge clock); #1;
    checkOutput("s6_done", done, 1);
    checkOutput("s6_req", req_count - req_base, 4);
    check_writes("s6", wr_base);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
